// File: rtl/nios_system_link_pkg.sv
// Shared types and constants for the board-to-board link controller.
// Holds the sequencer states, register map and bit positions.
package nios_system_link_pkg;

   typedef enum logic [2:0] {
      IDLE,
      TX_SETUP,
      TX_REQ,
      TX_DONE,
      RX_ACK,
      RX_WAIT
   } link_state_t;

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_STATUS  = 2'd1;
   localparam logic [1:0] ADDR_CONTROL = 2'd2;
   localparam logic [1:0] ADDR_SETUP   = 2'd3;

   localparam int STAT_TX_BUSY    = 0;
   localparam int STAT_RX_VALID   = 1;
   localparam int STAT_RX_OVERRUN = 2;
   localparam int STAT_COLLISION  = 3;
   localparam int STAT_TIMEOUT    = 4;

   localparam int CTRL_ENABLE = 0;
   localparam int CTRL_IRQ_EN = 1;

   // A zero setup time would leave no data-valid window before req.
   function automatic logic [7:0] setup_value(input logic [7:0] v);
      return (v == 8'd0) ? 8'd1 : v;
   endfunction

endpackage

// File: rtl/nios_system_link_ctrl_if.sv
// Avalon-MM slave bundle between the Nios II interconnect and the link.
// The controller takes the slave side; the CPU fabric takes the master side.
interface nios_system_link_ctrl_if;

   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic        read_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        irq;

   modport master (
      output address, chipselect, write_n, read_n, writedata,
      input  readdata, irq
   );

   modport slave (
      input  address, chipselect, write_n, read_n, writedata,
      output readdata, irq
   );

endinterface

// File: rtl/nios_system_link_sync.sv
// Two-flop synchronizer of configurable width for the link header inputs.
// Clears to zero on reset so the sequencer never sees stale requests.
module nios_system_link_sync #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] i_async,
   output logic [WIDTH-1:0] o_sync
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   // Two register stages to settle metastability from the peer board
   always_ff @(posedge clk) begin
      if (reset) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
      end
   end

   assign o_sync = r_sync;

endmodule

// File: rtl/nios_system_link_ctrl.sv
// Avalon-MM controller driving the 8-bit half-duplex board link (req/ack).
// Optional macro LINK_TIMEOUT_EN bounds every handshake wait.
module nios_system_link_ctrl
   import nios_system_link_pkg::*;
#(
   parameter int IS_MASTER      = 1,
   parameter int SETUP_DEFAULT  = 4,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic                    clk,
   input  logic                    reset,
   nios_system_link_ctrl_if.slave  avs,
   inout  wire  [7:0]              link_data,
   output logic                    link_req_out,
   output logic                    link_ack_out,
   input  logic                    link_req_in,
   input  logic                    link_ack_in
);

   localparam bit YIELD = (IS_MASTER == 0);

   link_state_t r_state;
   logic        r_oe;
   logic        r_req_out;
   logic        r_ack_out;
   logic [7:0]  r_tx_byte;
   logic        r_tx_pending;
   logic [7:0]  r_rx_byte;
   logic        r_rx_valid;
   logic        r_rx_overrun;
   logic        r_collision;
   logic        r_enable;
   logic        r_irq_en;
   logic [7:0]  r_setup;
   logic [7:0]  r_setup_cnt;
   logic [31:0] r_readdata;
   logic        r_irq;

   logic [1:0]  w_hs_sync;
   logic [7:0]  w_data_sync;
   logic        w_req_in;
   logic        w_ack_in;
   logic        w_wr;
   logic        w_rd;
   logic        w_tx_busy;
   logic        w_tx_accept;
   logic        w_rd_data;
   logic        w_wr_status;
   logic        w_timeout;
   logic [31:0] w_status;
   logic        w_unused;

   nios_system_link_sync #(.WIDTH(2)) u_sync_hs (
      .clk     (clk),
      .reset   (reset),
      .i_async ({link_req_in, link_ack_in}),
      .o_sync  (w_hs_sync)
   );

   nios_system_link_sync #(.WIDTH(8)) u_sync_data (
      .clk     (clk),
      .reset   (reset),
      .i_async (link_data),
      .o_sync  (w_data_sync)
   );

   assign w_req_in = w_hs_sync[1];
   assign w_ack_in = w_hs_sync[0];

   assign w_wr = avs.chipselect & ~avs.write_n;
   assign w_rd = avs.chipselect & ~avs.read_n;

   assign w_tx_busy = r_tx_pending |
                      (r_state inside {TX_SETUP, TX_REQ, TX_DONE});

   // A byte written while busy is dropped so the driven byte stays stable.
   assign w_tx_accept = w_wr & (avs.address == ADDR_DATA) & ~w_tx_busy;
   assign w_rd_data   = w_rd & (avs.address == ADDR_DATA);
   assign w_wr_status = w_wr & (avs.address == ADDR_STATUS);

`ifdef LINK_TIMEOUT_EN
   logic        r_timeout;
   logic [15:0] r_to_cnt;
   logic        w_wait_st;
   logic        w_to_hit;

   assign w_wait_st = r_state inside {TX_REQ, TX_DONE, RX_WAIT};
   assign w_to_hit  = w_wait_st &
                      (r_to_cnt == 16'(TIMEOUT_CYCLES - 1));
   assign w_timeout = r_timeout;
`else
   assign w_timeout = 1'b0;
`endif

   assign w_status = {27'd0, w_timeout, r_collision,
                      r_rx_overrun, r_rx_valid, w_tx_busy};

   assign w_unused = ^{avs.writedata, TIMEOUT_CYCLES[0]};

   assign link_data    = r_oe ? r_tx_byte : 8'bz;
   assign link_req_out = r_req_out;
   assign link_ack_out = r_ack_out;
   assign avs.readdata = r_readdata;
   assign avs.irq      = r_irq;

   // Host configuration, transmit byte latch, read data and interrupt
   always_ff @(posedge clk) begin
      if (reset) begin
         r_enable   <= 1'b0;
         r_irq_en   <= 1'b0;
         r_setup    <= 8'(SETUP_DEFAULT);
         r_tx_byte  <= 8'd0;
         r_readdata <= 32'd0;
         r_irq      <= 1'b0;
      end else begin
         if (w_wr && avs.address == ADDR_CONTROL) begin
            r_enable <= avs.writedata[CTRL_ENABLE];
            r_irq_en <= avs.writedata[CTRL_IRQ_EN];
         end
         if (w_wr && avs.address == ADDR_SETUP)
            r_setup <= setup_value(avs.writedata[7:0]);
         if (w_tx_accept)
            r_tx_byte <= avs.writedata[7:0];
         if (w_rd) begin
            unique case (1'b1)
               avs.address == ADDR_DATA:
                  r_readdata <= {24'd0, r_rx_byte};
               avs.address == ADDR_STATUS:
                  r_readdata <= w_status;
               avs.address == ADDR_CONTROL:
                  r_readdata <= {30'd0, r_irq_en, r_enable};
               default:
                  r_readdata <= {24'd0, r_setup};
            endcase
         end
         r_irq <= r_irq_en & (r_rx_valid | r_rx_overrun);
      end
   end

   // Handshake sequencer together with the status flags it owns
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_oe         <= 1'b0;
         r_req_out    <= 1'b0;
         r_ack_out    <= 1'b0;
         r_tx_pending <= 1'b0;
         r_rx_byte    <= 8'd0;
         r_rx_valid   <= 1'b0;
         r_rx_overrun <= 1'b0;
         r_collision  <= 1'b0;
         r_setup_cnt  <= 8'd0;
`ifdef LINK_TIMEOUT_EN
         r_timeout    <= 1'b0;
         r_to_cnt     <= 16'd0;
`endif
      end else begin
         if (w_tx_accept)
            r_tx_pending <= 1'b1;
         if (w_rd_data)
            r_rx_valid <= 1'b0;
         if (w_wr_status && avs.writedata[STAT_RX_OVERRUN])
            r_rx_overrun <= 1'b0;
         if (w_wr_status && avs.writedata[STAT_COLLISION])
            r_collision <= 1'b0;
`ifdef LINK_TIMEOUT_EN
         if (w_wr_status && avs.writedata[STAT_TIMEOUT])
            r_timeout <= 1'b0;
         r_to_cnt <= w_wait_st ? r_to_cnt + 16'd1 : 16'd0;
`endif
         case (r_state)
            IDLE: begin
               if (r_enable) begin
                  if (w_req_in) begin
                     r_state <= RX_ACK;
                  end else if (r_tx_pending) begin
                     r_state     <= TX_SETUP;
                     r_oe        <= 1'b1;
                     r_setup_cnt <= r_setup;
                  end
               end
            end
            TX_SETUP: begin
               if (YIELD && w_req_in) begin
                  r_oe        <= 1'b0;
                  r_collision <= 1'b1;
                  r_state     <= RX_ACK;
               end else if (r_setup_cnt <= 8'd1) begin
                  r_req_out <= 1'b1;
                  r_state   <= TX_REQ;
               end else begin
                  r_setup_cnt <= r_setup_cnt - 8'd1;
               end
            end
            TX_REQ: begin
               if (w_ack_in) begin
                  r_req_out <= 1'b0;
                  r_oe      <= 1'b0;
                  r_state   <= TX_DONE;
               end
            end
            TX_DONE: begin
               if (!w_ack_in) begin
                  r_tx_pending <= 1'b0;
                  r_state      <= IDLE;
               end
            end
            RX_ACK: begin
               // Capture beats a same-cycle host read of the data register.
               r_rx_byte  <= w_data_sync;
               r_rx_valid <= 1'b1;
               if (r_rx_valid)
                  r_rx_overrun <= 1'b1;
               r_ack_out  <= 1'b1;
               r_state    <= RX_WAIT;
            end
            RX_WAIT: begin
               if (!w_req_in) begin
                  r_ack_out <= 1'b0;
                  r_state   <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
`ifdef LINK_TIMEOUT_EN
         if (w_to_hit) begin
            r_req_out    <= 1'b0;
            r_ack_out    <= 1'b0;
            r_oe         <= 1'b0;
            r_tx_pending <= 1'b0;
            r_timeout    <= 1'b1;
            r_to_cnt     <= 16'd0;
            r_state      <= IDLE;
         end
`endif
      end
   end

endmodule

// File: tb/tb_nios_system_link_ctrl.sv
// Directed bench: one IS_MASTER=1 controller and one IS_MASTER=0 controller.
// Each has its own Avalon bundle and a scripted peer on its link pins.
module tb_nios_system_link_ctrl;
   import nios_system_link_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   nios_system_link_ctrl_if m_if ();
   nios_system_link_ctrl_if s_if ();

   wire  [7:0] m_data;
   wire  [7:0] s_data;
   logic       m_req_out, m_ack_out, s_req_out, s_ack_out;
   logic       m_req_in = 1'b0, m_ack_in = 1'b0, m_peer_oe = 1'b0;
   logic       s_req_in = 1'b0, s_ack_in = 1'b0;
   logic [7:0] m_peer_byte = 8'd0;
   logic [31:0] rd;
   int          cnt;

   assign m_data = m_peer_oe ? m_peer_byte : 8'bz;

   nios_system_link_ctrl #(
      .IS_MASTER(1), .SETUP_DEFAULT(4), .TIMEOUT_CYCLES(100)
   ) u_m (
      .clk(clk), .reset(reset), .avs(m_if),
      .link_data(m_data),
      .link_req_out(m_req_out), .link_ack_out(m_ack_out),
      .link_req_in(m_req_in), .link_ack_in(m_ack_in)
   );

   nios_system_link_ctrl #(
      .IS_MASTER(0), .SETUP_DEFAULT(4), .TIMEOUT_CYCLES(100)
   ) u_s (
      .clk(clk), .reset(reset), .avs(s_if),
      .link_data(s_data),
      .link_req_out(s_req_out), .link_ack_out(s_ack_out),
      .link_req_in(s_req_in), .link_ack_in(s_ack_in)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit s, input logic cs, input logic wn,
                        input logic rn, input logic [1:0] a,
                        input logic [31:0] d);
      if (s) begin
         s_if.chipselect = cs; s_if.write_n = wn; s_if.read_n = rn;
         s_if.address = a; s_if.writedata = d;
      end else begin
         m_if.chipselect = cs; m_if.write_n = wn; m_if.read_n = rn;
         m_if.address = a; m_if.writedata = d;
      end
   endtask

   task automatic bus_write(input bit s, input logic [1:0] a,
                            input logic [31:0] d);
      @(negedge clk); drive(s, 1'b1, 1'b0, 1'b1, a, d);
      @(negedge clk); drive(s, 1'b0, 1'b1, 1'b1, 2'd0, 32'd0);
   endtask

   task automatic bus_read(input bit s, input logic [1:0] a,
                           output logic [31:0] d);
      @(negedge clk); drive(s, 1'b1, 1'b1, 1'b0, a, 32'd0);
      @(negedge clk); drive(s, 1'b0, 1'b1, 1'b1, 2'd0, 32'd0);
      d = s ? s_if.readdata : m_if.readdata;
   endtask

   task automatic m_peer_send(input logic [7:0] b);
      m_peer_byte = b; m_peer_oe = 1'b1; m_req_in = 1'b1;
      for (int i = 0; i < 50 && m_ack_out !== 1'b1; i++) @(negedge clk);
      check("peer_ack_rise", m_ack_out, 1);
      m_req_in = 1'b0; m_peer_oe = 1'b0;
      for (int i = 0; i < 50 && m_ack_out !== 1'b0; i++) @(negedge clk);
      check("peer_ack_fall", m_ack_out, 0);
   endtask

   initial begin
      drive(1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 32'd0);
      drive(1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // reset state
      check("rst_readdata", m_if.readdata, 0);
      check("rst_irq", m_if.irq, 0);
      check("rst_req_out", m_req_out, 0);
      check("rst_ack_out", m_ack_out, 0);
      check("rst_bus_released", u_m.r_oe, 0);
      bus_read(0, ADDR_DATA, rd);    check("rst_data", rd, 32'h0);
      bus_read(0, ADDR_STATUS, rd);  check("rst_status", rd, 32'h0);
      bus_read(0, ADDR_CONTROL, rd); check("rst_control", rd, 32'h0);
      bus_read(0, ADDR_SETUP, rd);   check("rst_setup", rd, 32'h4);

      // setup register: zero is stored as one
      bus_write(0, ADDR_SETUP, 32'h0);
      bus_read(0, ADDR_SETUP, rd);   check("setup_zero", rd, 32'h1);
      bus_write(0, ADDR_SETUP, 32'h104);
      bus_read(0, ADDR_SETUP, rd);   check("setup_four", rd, 32'h4);

      // transmit 0xA5
      bus_write(0, ADDR_CONTROL, 32'h3);
      bus_read(0, ADDR_CONTROL, rd); check("control_rw", rd, 32'h3);
      bus_write(0, ADDR_DATA, 32'hA5);
      check("tx_not_yet_driven", u_m.r_oe, 0);
      @(negedge clk);
      check("tx_drive_latency", m_data, 8'hA5);
      cnt = 0;
      for (int i = 0; i < 50 && m_req_out !== 1'b1; i++) begin
         if (m_data === 8'hA5 && m_req_out === 1'b0) cnt++;
         @(negedge clk);
      end
      check("tx_setup_cycles", cnt, 4);
      check("tx_req_rise", m_req_out, 1);
      repeat (10) @(negedge clk);
      m_ack_in = 1'b1;
      for (int i = 0; i < 20 && m_req_out !== 1'b0; i++) @(negedge clk);
      check("tx_req_fall", m_req_out, 0);
      check("tx_bus_released", u_m.r_oe, 0);
      bus_read(0, ADDR_STATUS, rd);  check("tx_busy_until_ack_low", rd, 32'h1);
      m_ack_in = 1'b0;
      repeat (5) @(negedge clk);
      bus_read(0, ADDR_STATUS, rd);  check("tx_done_status", rd, 32'h0);

      // receive 0x3C
      m_peer_send(8'h3C);
      repeat (2) @(negedge clk);
      check("rx_irq_set", m_if.irq, 1);
      bus_read(0, ADDR_STATUS, rd);  check("rx_status", rd, 32'h2);
      bus_read(0, ADDR_DATA, rd);    check("rx_byte", rd, 32'h3C);
      repeat (2) @(negedge clk);
      check("rx_irq_clear", m_if.irq, 0);
      bus_read(0, ADDR_STATUS, rd);  check("rx_valid_clear", rd, 32'h0);

      // overrun
      m_peer_send(8'h11);
      m_peer_send(8'h22);
      bus_read(0, ADDR_STATUS, rd);  check("ovr_status", rd, 32'h6);
      bus_read(0, ADDR_DATA, rd);    check("ovr_last_byte", rd, 32'h22);
      bus_write(0, ADDR_STATUS, 32'h4);
      bus_read(0, ADDR_STATUS, rd);  check("ovr_w1c", rd, 32'h0);

      // collision on the non-master controller
      bus_write(1, ADDR_CONTROL, 32'h1);
      bus_write(1, ADDR_DATA, 32'h77);
      for (int i = 0; i < 10 && u_s.r_oe !== 1'b1; i++) @(negedge clk);
      check("col_setup_drive", s_data, 8'h77);
      s_req_in = 1'b1;
      for (int i = 0; i < 10 && u_s.r_oe !== 1'b0; i++) @(negedge clk);
      check("col_oe_drop", u_s.r_oe, 0);
      check("col_no_req", s_req_out, 0);
      @(negedge clk);
      check("col_ack_rise", s_ack_out, 1);
      bus_read(1, ADDR_STATUS, rd);  check("col_status", rd, 32'hB);
      bus_write(1, ADDR_DATA, 32'h99);
      s_req_in = 1'b0;
      for (int i = 0; i < 50 && s_req_out !== 1'b1; i++) @(negedge clk);
      check("col_retry_req", s_req_out, 1);
      check("col_retry_byte", s_data, 8'h77);
      s_ack_in = 1'b1;
      for (int i = 0; i < 20 && s_req_out !== 1'b0; i++) @(negedge clk);
      check("col_retry_done", s_req_out, 0);
      s_ack_in = 1'b0;
      repeat (5) @(negedge clk);
      bus_read(1, ADDR_STATUS, rd);  check("col_after", rd, 32'hA);
      bus_write(1, ADDR_STATUS, 32'h8);
      bus_read(1, ADDR_STATUS, rd);  check("col_w1c", rd, 32'h2);

`ifdef LINK_TIMEOUT_EN
      // peer never acknowledges
      bus_write(0, ADDR_DATA, 32'h5A);
      for (int i = 0; i < 20 && m_req_out !== 1'b1; i++) @(negedge clk);
      check("to_req_rise", m_req_out, 1);
      cnt = 0;
      for (int i = 0; i < 300 && m_req_out === 1'b1; i++) begin
         cnt++;
         @(negedge clk);
      end
      check("to_cycles", cnt, 100);
      check("to_bus_released", u_m.r_oe, 0);
      bus_read(0, ADDR_STATUS, rd);  check("to_status", rd, 32'h10);
      bus_write(0, ADDR_STATUS, 32'h10);
      bus_read(0, ADDR_STATUS, rd);  check("to_w1c", rd, 32'h0);
`endif

      // reset in the middle of a transfer
      bus_write(0, ADDR_DATA, 32'h33);
      for (int i = 0; i < 20 && m_req_out !== 1'b1; i++) @(negedge clk);
      check("mid_req_rise", m_req_out, 1);
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_req", m_req_out, 0);
      check("mid_rst_oe", u_m.r_oe, 0);
      reset = 1'b0;
      bus_read(0, ADDR_STATUS, rd);  check("mid_rst_status", rd, 32'h0);
      bus_read(0, ADDR_CONTROL, rd); check("mid_rst_control", rd, 32'h0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
